sram_arbiter_2p: RTL and testbench
==================================

// Module: sram_arbiter_2p
// PURPOSE
//   Shares one external 16-bit async SRAM (21-bit word address, UB/LB byte lanes) between two requesters A and B.
//   Each requester presents one word transaction under a req/ack handshake; the arbiter grants round-robin,
//   sequences the SRAM read/write strobes and returns read data. Sits between the SRAM pins and e.g. CPU/video.
// PARAMETERS
//   RD_WAIT   1  cycles address is held on sram_a before sram_d is sampled (1..15)
//   WR_PULSE  1  cycles sram_we_n is held low per write (1..15)
// PORTS
//   clk        in   1   system clock
//   reset      in   1   synchronous, active-high
//   a_req      in   1   A transaction request, held high until a_ack
//   a_we       in   1   A: 1=write, 0=read (stable while a_req)
//   a_addr     in   21  A word address
//   a_wdata    in   16  A write data
//   a_be       in   2   A byte enables, [1]=upper, [0]=lower, active-high
//   a_ack      out  1   A one-cycle completion strobe
//   a_rdata    out  16  A read data, valid in a_ack cycle, held until next A read
//   b_*        (same set as A, for requester B)
//   busy       out  1   high in every non-IDLE state
//   sram_a     out  21  SRAM address
//   sram_d     inout 16 SRAM data; driven only during write states, else 'z
//   sram_we_n  out  1   SRAM write enable, active-low
//   sram_ub_n  out  1   upper byte enable, active-low
//   sram_lb_n  out  1   lower byte enable, active-low
// BEHAVIOUR
//   Reset values: sram_a=0, sram_we_n=1, sram_ub_n=1, sram_lb_n=1, sram_d='z, a/b_ack=0, a/b_rdata=0, busy=0,
//     state=IDLE, last_grant=B (so A wins the first tie). All outputs registered.
//   States: IDLE, RD, WR_SETUP, WR_PULSE, DONE. Wait counter 4 bits.
//   IDLE: if any req, pick winner: only one req -> that one; both -> port not in last_grant. Latch we/addr/wdata/be,
//     set last_grant, sram_a<=addr, sram_ub_n<=~be[1], sram_lb_n<=~be[0]; go RD (cnt=RD_WAIT) or WR_SETUP.
//   RD: decrement cnt; at cnt==1 capture sram_d into winner's rdata, assert winner ack, go DONE.
//   WR_SETUP: sram_d driven with wdata, we_n=1 (address/data setup); go WR_PULSE, cnt=WR_PULSE.
//   WR_PULSE: we_n=0, data driven; at cnt==1 go DONE with we_n<=1 and winner ack.
//   DONE (one cycle): ack high, rdata valid; write data still driven (hold), we_n=1; ub/lb<=1; next IDLE.
//   Latency from first IDLE cycle with req high (cycle 0): read ack in cycle RD_WAIT+1; write ack in
//     cycle WR_PULSE+2; we_n low exactly WR_PULSE cycles. Next grant evaluated cycle after DONE.
//   Requester must drop req (or present a new transaction) in the cycle after ack; req sampled only in IDLE.
//   A req rising while the other port is served waits; never dropped. No starvation: alternates on contention.
//   Zero byte enables: transaction still executes, both ub/lb stay 1, ack as normal.
//   sram_we_n never low except WR_PULSE; sram_d never driven while we_n can be low with different data.
//   Address/data/be latched at grant; changes on requester inputs after grant have no effect.
//   Reset mid-transaction: next edge forces reset values (we_n=1, bus 'z), no ack issued, transaction lost.
//   Address wrap: none; sram_a = requested address exactly, 21'h1FFFFF legal.
// TESTING
//   Read, RD_WAIT=1: A read addr 21'h000123, SRAM model returns 16'hBEEF -> a_ack in cycle 2, a_rdata=16'hBEEF.
//   Write: B write addr 21'h07FFFF data 16'h5555 be=2'b11 -> we_n low 1 cycle, b_ack cycle 3, model holds 16'h5555.
//   Byte lane: A write be=2'b10 data 16'hAA00 over 16'h1234 -> ub_n=0, lb_n=1, readback 16'hAA34.
//   Contention: A and B req same cycle, both repeat 4 transactions -> grant order A,B,A,B,...; 8 acks, no loss.
//   Reset mid-write: assert reset during WR_PULSE -> next cycle we_n=1, sram_d='z, no ack, busy=0.
//   Timing params RD_WAIT=3, WR_PULSE=2: read ack cycle 4, write we_n low 2 cycles, ack cycle 4.

Source files
------------

// File: rtl/sram_arbiter_2p.sv
// sram_arbiter_2p: round-robin arbiter sharing one async 16-bit SRAM between requesters A and B
module sram_arbiter_2p #(
  parameter int RD_WAIT  = 1,
  parameter int WR_PULSE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [20:0] a_addr,
  input  logic [15:0] a_wdata,
  input  logic [1:0]  a_be,
  output logic        a_ack,
  output logic [15:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [20:0] b_addr,
  input  logic [15:0] b_wdata,
  input  logic [1:0]  b_be,
  output logic        b_ack,
  output logic [15:0] b_rdata,
  output logic        busy,
  output logic [20:0] sram_a,
  inout  wire  [15:0] sram_d,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);
  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR_SETUP, S_WR_PULSE, S_DONE} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [15:0] wd;
  logic [1:0] be;
  logic sel, last_b, drv, go, pick_b, req_we, last_cnt;
  assign go       = a_req | b_req;
  assign pick_b   = b_req & (~a_req | ~last_b);
  assign req_we   = pick_b ? b_we : a_we;
  assign be       = pick_b ? b_be : a_be;
  assign last_cnt = cnt == 4'd1;
  assign sram_d   = drv ? wd : 'z;
  // next state and wait-counter sequencing
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      S_IDLE: if (go) begin
        state_n = req_we ? S_WR_SETUP : S_RD;
        cnt_n   = 4'(RD_WAIT);
      end
      S_RD, S_WR_PULSE: begin
        cnt_n = cnt - 4'd1;
        if (last_cnt) state_n = S_DONE;
      end
      S_WR_SETUP: begin
        state_n = S_WR_PULSE;
        cnt_n   = 4'(WR_PULSE);
      end
      default: state_n = S_IDLE;
    endcase
  end
  // state, counter and busy registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      busy  <= state_n != S_IDLE;
    end
  end
  // grant latching, SRAM strobes and requester responses
  always_ff @(posedge clk) begin
    if (reset) begin
      sel       <= 1'b0;
      last_b    <= 1'b1;
      drv       <= 1'b0;
      wd        <= '0;
      sram_a    <= '0;
      sram_we_n <= 1'b1;
      sram_ub_n <= 1'b1;
      sram_lb_n <= 1'b1;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      case (state)
        S_IDLE: if (go) begin
          sel       <= pick_b;
          last_b    <= pick_b;
          drv       <= req_we;
          sram_a    <= pick_b ? b_addr : a_addr;
          wd        <= pick_b ? b_wdata : a_wdata;
          sram_ub_n <= ~be[1];
          sram_lb_n <= ~be[0];
        end
        S_RD: if (last_cnt) begin
          if (sel) b_rdata <= sram_d;
          else a_rdata <= sram_d;
          a_ack <= ~sel;
          b_ack <= sel;
        end
        S_WR_SETUP: sram_we_n <= 1'b0;
        S_WR_PULSE: if (last_cnt) begin
          sram_we_n <= 1'b1;
          a_ack     <= ~sel;
          b_ack     <= sel;
        end
        S_DONE: begin
          sram_ub_n <= 1'b1;
          sram_lb_n <= 1'b1;
          drv       <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_arbiter_2p.sv
// tb_sram_arbiter_2p: randomized and directed bench against a latency-level model of the arbiter
module tb_sram_arbiter_2p;
  localparam int RW = 1, WP = 1;
  logic clk = 1'b0, reset = 1'b1, live = 1'b0;
  always #5 clk = ~clk;
  logic a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [20:0] a_addr = 0, b_addr = 0;
  logic [15:0] a_wdata = 0, b_wdata = 0;
  logic [1:0] a_be = 0, b_be = 0;
  logic a_ack, b_ack, busy, sram_we_n, sram_ub_n, sram_lb_n;
  logic [15:0] a_rdata, b_rdata;
  logic [20:0] sram_a;
  wire [15:0] sram_d;
  logic bus_drv = 0;
  logic [15:0] bus_val = 0;
  assign sram_d = bus_drv ? bus_val : 16'hzzzz;

  sram_arbiter_2p #(.RD_WAIT(RW), .WR_PULSE(WP)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be), .b_ack(b_ack), .b_rdata(b_rdata),
    .busy(busy), .sram_a(sram_a), .sram_d(sram_d), .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  logic c_req = 0, c_we = 0, c_ack, zb_ack, busy2, we2, ub2, lb2, drv2 = 0;
  logic [20:0] c_addr = 0, a2;
  logic [15:0] c_wdata = 0, c_rdata, zb_rdata;
  wire [15:0] d2;
  assign d2 = drv2 ? 16'h7E57 : 16'hzzzz;

  sram_arbiter_2p #(.RD_WAIT(3), .WR_PULSE(2)) u2 (
    .clk(clk), .reset(reset),
    .a_req(c_req), .a_we(c_we), .a_addr(c_addr), .a_wdata(c_wdata), .a_be(2'b11), .a_ack(c_ack), .a_rdata(c_rdata),
    .b_req(1'b0), .b_we(1'b0), .b_addr(21'h0), .b_wdata(16'h0), .b_be(2'b00), .b_ack(zb_ack), .b_rdata(zb_rdata),
    .busy(busy2), .sram_a(a2), .sram_d(d2), .sram_we_n(we2), .sram_ub_n(ub2), .sram_lb_n(lb2)
  );

  int n_cmp = 0, n_bad = 0, welow = 0;
  logic w_ub = 1, w_lb = 1;
  logic [15:0] smem [logic [20:0]];
  logic [15:0] rmem [logic [20:0]];
  logic [20:0] pool [8] = '{21'h0, 21'h1, 21'h123, 21'h456, 21'h7FFFF, 21'h1FFFFF, 21'h100000, 21'h0FFFF0};

  function automatic logic [15:0] sread(input logic [20:0] ad);
    return smem.exists(ad) ? smem[ad] : 16'h0;
  endfunction
  function automatic logic [15:0] rref(input logic [20:0] ad);
    return rmem.exists(ad) ? rmem[ad] : 16'h0;
  endfunction
  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw, input logic [1:0] be);
    return {be[1] ? nw[15:8] : old[15:8], be[0] ? nw[7:0] : old[7:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a transaction occupies ages 1..len after its grant cycle (age 0); ack lands on age len.
  int ph = 0, m_len = 2;
  logic m_sel = 0, m_last = 1, m_we = 0;
  logic [20:0] m_addr = 0;
  logic [15:0] m_wd = 0, m_ard = 0, m_brd = 0;
  logic [1:0] m_be = 0;
  logic gq[$];
  wire m_pick_b = b_req && (!a_req || !m_last);

  always @(posedge clk) begin
    if (reset) begin
      ph <= 0; m_last <= 1; m_we <= 0; m_be <= 0; m_addr <= 0; m_ard <= 0; m_brd <= 0;
    end else if (ph == 0) begin
      if (a_req || b_req) begin
        m_sel  <= m_pick_b;
        m_last <= m_pick_b;
        m_we   <= m_pick_b ? b_we : a_we;
        m_addr <= m_pick_b ? b_addr : a_addr;
        m_wd   <= m_pick_b ? b_wdata : a_wdata;
        m_be   <= m_pick_b ? b_be : a_be;
        m_len  <= (m_pick_b ? b_we : a_we) ? WP + 2 : RW + 1;
        ph     <= 1;
        gq.push_back(m_pick_b);
      end
    end else begin
      ph <= (ph == m_len) ? 0 : ph + 1;
      if (ph == m_len - 1) begin
        if (m_we) rmem[m_addr] = merge(rref(m_addr), m_wd, m_be);
        else if (m_sel) m_brd <= rref(m_addr);
        else m_ard <= rref(m_addr);
      end
    end
  end

  // Per-cycle comparison plus the SRAM device model on the pins.
  always @(negedge clk) if (live) begin
    chk("busy", busy, 32'(ph != 0));
    chk("a_ack", 32'(a_ack), 32'(ph != 0 && ph == m_len && !m_sel));
    chk("b_ack", 32'(b_ack), 32'(ph != 0 && ph == m_len && m_sel));
    chk("we_n", 32'(sram_we_n), 32'(!(m_we && ph >= 2 && ph <= WP + 1)));
    chk("ub_n", 32'(sram_ub_n), 32'(!(ph >= 1 && m_be[1])));
    chk("lb_n", 32'(sram_lb_n), 32'(!(ph >= 1 && m_be[0])));
    chk("sram_a", 32'(sram_a), 32'(m_addr));
    chk("a_rdata", 32'(a_rdata), 32'(m_ard));
    chk("b_rdata", 32'(b_rdata), 32'(m_brd));
    if (ph >= 1 && m_we) chk("sram_d", 32'(sram_d), 32'(m_wd));
    if (!sram_we_n) begin
      smem[sram_a] = merge(sread(sram_a), sram_d, ~{sram_ub_n, sram_lb_n});
      welow++;
      w_ub = sram_ub_n;
      w_lb = sram_lb_n;
    end
    bus_drv = ph >= 1 && !m_we;
    bus_val = sread(sram_a);
  end

  task automatic txn(input bit p, input bit we, input logic [20:0] ad, input logic [15:0] wd,
                     input logic [1:0] be, input bit scr, output int cyc);
    if (p) begin b_req = 1; b_we = we; b_addr = ad; b_wdata = wd; b_be = be; end
    else begin a_req = 1; a_we = we; a_addr = ad; a_wdata = wd; a_be = be; end
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (p ? b_ack : a_ack) break;
      if (cyc >= 300) begin
        n_cmp++; n_bad++;
        $display("FAIL timeout port %0d: no ack after %0d cycles, expected ack", p, cyc);
        break;
      end
      if (scr) begin
        if (p) begin b_addr = pool[$urandom_range(0, 7)]; b_wdata = 16'($urandom); b_be = 2'($urandom_range(0, 3)); end
        else begin a_addr = pool[$urandom_range(0, 7)]; a_wdata = 16'($urandom); a_be = 2'($urandom_range(0, 3)); end
      end
    end
    if (p) b_req = 0; else a_req = 0;
  endtask

  task automatic dtx(input bit p, input bit we, input logic [20:0] ad, input logic [15:0] wd,
                     input logic [1:0] be, output int cyc);
    @(negedge clk);
    txn(p, we, ad, wd, be, 0, cyc);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, lo;
    logic [15:0] dw;
    smem[21'h000123] = 16'hBEEF; rmem[21'h000123] = 16'hBEEF;
    smem[21'h000456] = 16'h1234; rmem[21'h000456] = 16'h1234;
    repeat (2) @(posedge clk);
    live = 1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_we_n", 32'(sram_we_n), 1);
    chk("rst_ub_n", 32'(sram_ub_n), 1);
    chk("rst_sram_a", 32'(sram_a), 0);
    chk("rst_a_rdata", 32'(a_rdata), 0);
    reset = 0;
    dtx(0, 0, 21'h000123, 16'h0, 2'b11, c);
    chk("rd_lat", 32'(c), 2);
    chk("rd_data", 32'(a_rdata), 32'h BEEF);
    lo = welow;
    dtx(1, 1, 21'h07FFFF, 16'h5555, 2'b11, c);
    chk("wr_lat", 32'(c), 3);
    chk("wr_we_low", 32'(welow - lo), 1);
    chk("wr_mem", 32'(sread(21'h07FFFF)), 32'h5555);
    dtx(0, 1, 21'h000456, 16'hAA00, 2'b10, c);
    chk("bl_ub_n", 32'(w_ub), 0);
    chk("bl_lb_n", 32'(w_lb), 1);
    dtx(0, 0, 21'h000456, 16'h0, 2'b11, c);
    chk("bl_rd", 32'(a_rdata), 32'hAA34);
    dtx(1, 1, 21'h000456, 16'hFFFF, 2'b00, c);
    chk("zbe_lat", 32'(c), 3);
    dtx(1, 0, 21'h000456, 16'h0, 2'b11, c);
    chk("zbe_rd", 32'(b_rdata), 32'hAA34);
    dtx(1, 1, 21'h1FFFFF, 16'hC3C3, 2'b11, c);
    dtx(1, 0, 21'h1FFFFF, 16'h0, 2'b11, c);
    chk("top_rd", 32'(b_rdata), 32'hC3C3);
    @(negedge clk);
    gq.delete();
    fork
      begin
        int ca;
        for (int i = 0; i < 4; i++) txn(0, 1, 21'h10 + 21'(i), 16'($urandom), 2'b11, 0, ca);
      end
      begin
        int cb;
        for (int i = 0; i < 4; i++) txn(1, 0, 21'h20 + 21'(i), 16'h0, 2'b11, 0, cb);
      end
    join
    chk("cont_count", 32'(gq.size()), 8);
    for (int i = 0; i < 8 && i < gq.size(); i++) chk("cont_order", 32'(gq[i]), 32'(i % 2));
    @(negedge clk);
    a_req = 1; a_we = 1; a_addr = 21'h0ABCDE; a_wdata = 16'h0F0F; a_be = 2'b11;
    for (c = 0; c < 20 && sram_we_n; c++) @(negedge clk);
    chk("rstm_reach_pulse", 32'(sram_we_n), 0);
    reset = 1; a_req = 0;
    @(negedge clk);
    chk("rstm_we_n", 32'(sram_we_n), 1);
    chk("rstm_busy", 32'(busy), 0);
    chk("rstm_ack", 32'(a_ack), 0);
    reset = 0;
    @(negedge clk);
    fork
      begin
        int ca;
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          txn(0, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], 16'($urandom), 2'($urandom_range(0, 3)), 1, ca);
        end
      end
      begin
        int cb;
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          txn(1, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], 16'($urandom), 2'($urandom_range(0, 3)), 1, cb);
        end
      end
    join
    @(negedge clk);
    c_req = 1; c_we = 0; c_addr = 21'h5; drv2 = 1;
    for (c = 0; c < 50;) begin
      @(negedge clk);
      c++;
      if (c_ack) break;
    end
    chk("p2_rd_lat", 32'(c), 4);
    chk("p2_rd_data", 32'(c_rdata), 32'h7E57);
    c_req = 0; drv2 = 0;
    @(negedge clk);
    c_req = 1; c_we = 1; c_wdata = 16'h3C5A; lo = 0; dw = 0;
    for (c = 0; c < 50;) begin
      @(negedge clk);
      c++;
      if (!we2) begin lo++; dw = d2; end
      if (c_ack) break;
    end
    c_req = 0;
    chk("p2_wr_lat", 32'(c), 4);
    chk("p2_we_low", 32'(lo), 2);
    chk("p2_wr_data", 32'(dw), 32'h3C5A);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
